// File: rtl/i2c_slave_fsm_if.sv
// Bus and FIFO handshake bundle for the I2C target controller.
// The slave side is the controller; the master side is its environment (pads + FIFOs).
interface i2c_slave_fsm_if;
  logic       i2c_scl_i;
  logic       i2c_sda_i;
  logic [7:0] tx_data_i;
  logic       tx_empty_i;
  logic       tx_rd_en_o;
  logic       rx_full_i;
  logic [7:0] rx_data_o;
  logic       rx_wr_en_o;
  logic       sda_low_en_o;
  logic       scl_low_en_o;

  modport slave (
    input  i2c_scl_i, i2c_sda_i, tx_data_i, tx_empty_i, rx_full_i,
    output tx_rd_en_o, rx_data_o, rx_wr_en_o, sda_low_en_o, scl_low_en_o
  );

  modport master (
    output i2c_scl_i, i2c_sda_i, tx_data_i, tx_empty_i, rx_full_i,
    input  tx_rd_en_o, rx_data_o, rx_wr_en_o, sda_low_en_o, scl_low_en_o
  );
endinterface

// File: rtl/i2c_slave_fsm.sv
// I2C target (slave) controller, 7-bit address. Oversamples SCL/SDA on the
// core clock, detects START/STOP, ACKs its address and moves bytes between
// the bus and the RX/TX FIFOs.
// Optional feature: define I2C_SLAVE_CLK_STRETCH_EN to stretch SCL at byte
// boundaries instead of NACKing on a full RX FIFO / sending 8'hFF on an
// empty TX FIFO.
module i2c_slave_fsm #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic           i2c_core_clk_i,
  input  logic           reset_i,
  input  logic           enable_i,
  i2c_slave_fsm_if.slave bus,
  output logic           rw_o,
  output logic           busy_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDRESS  = 3'd1,
    ADDR_ACK = 3'd2,
    RX_DATA  = 3'd3,
    RX_ACK   = 3'd4,
    TX_DATA  = 3'd5,
    TX_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_e;

  // input conditioning
  logic [1:0] scl_sync, sda_sync;
  logic       scl_hist, sda_hist;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // state
  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_q, last_d;     // 8th bit of the byte has been sampled
  logic       nack_q, nack_d;     // RX byte NACKed, drop to IGNORE after the ACK slot
  logic       hold_q, hold_d;     // SCL stretch in progress
  logic       ack_q, ack_d;       // master ACK/NACK sampled in TX_ACK
  logic       sda_q, sda_d;
  logic       scl_q, scl_d;
  logic       tx_rd_q, tx_rd_d;
  logic       rx_wr_q, rx_wr_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;

  logic       addr_hit;
  logic [7:0] load_byte;

  // 2-flop synchronizers plus one history stage for edge detection
  always_ff @(posedge i2c_core_clk_i) begin
    scl_sync <= {scl_sync[0], bus.i2c_scl_i};
    sda_sync <= {sda_sync[0], bus.i2c_sda_i};
    scl_hist <= scl_sync[1];
    sda_hist <= sda_sync[1];
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  =  scl_s & ~scl_hist;
  assign scl_fall  = ~scl_s &  scl_hist;
  // SCL must have been high for two samples so a simultaneous SCL/SDA change is not a START/STOP
  assign start_det = scl_s & scl_hist &  sda_hist & ~sda_s;
  assign stop_det  = scl_s & scl_hist & ~sda_hist &  sda_s;

  assign addr_hit  = enable_i && (shift_q[7:1] == SLAVE_ADDR);
  // empty TX FIFO without stretching returns all ones (SDA released)
  assign load_byte = bus.tx_empty_i ? 8'hFF : bus.tx_data_i;

  // state register, synchronous reset
  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      cnt_q     <= 3'd7;
      last_q    <= 1'b0;
      nack_q    <= 1'b0;
      hold_q    <= 1'b0;
      ack_q     <= 1'b0;
      sda_q     <= 1'b0;
      scl_q     <= 1'b0;
      tx_rd_q   <= 1'b0;
      rx_wr_q   <= 1'b0;
      rx_data_q <= 8'h00;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      nack_q    <= nack_d;
      hold_q    <= hold_d;
      ack_q     <= ack_d;
      sda_q     <= sda_d;
      scl_q     <= scl_d;
      tx_rd_q   <= tx_rd_d;
      rx_wr_q   <= rx_wr_d;
      rx_data_q <= rx_data_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
    end
  end

  // next-state and output logic; STOP beats START beats per-state behaviour
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    nack_d    = nack_q;
    hold_d    = hold_q;
    ack_d     = ack_q;
    sda_d     = sda_q;
    scl_d     = 1'b0;
    tx_rd_d   = 1'b0;
    rx_wr_d   = 1'b0;
    rx_data_d = rx_data_q;
    rw_d      = rw_q;
    busy_d    = busy_q;

    if (stop_det) begin
      state_d = IDLE;
      sda_d   = 1'b0;
      busy_d  = 1'b0;
      hold_d  = 1'b0;
      nack_d  = 1'b0;
      cnt_d   = 3'd7;
      last_d  = 1'b0;
    end else if (start_det) begin
      // also a repeated START mid-byte: the partial byte is dropped
      state_d = ADDRESS;
      sda_d   = 1'b0;
      busy_d  = 1'b1;
      hold_d  = 1'b0;
      nack_d  = 1'b0;
      cnt_d   = 3'd7;
      last_d  = 1'b0;
      shift_d = 8'h00;
    end else begin
      case (state_q)
        IDLE: sda_d = 1'b0;

        ADDRESS: begin
          if (hold_q) begin
            // stretched write address: ACK once the RX FIFO has room
            scl_d = 1'b1;
            if (!bus.rx_full_i) begin
              hold_d  = 1'b0;
              sda_d   = 1'b1;
              state_d = ADDR_ACK;
            end
          end else if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (cnt_q == 3'd0) last_d = 1'b1;
            else               cnt_d  = cnt_q - 3'd1;
          end else if (scl_fall && last_q) begin
            last_d = 1'b0;
            if (addr_hit) begin
              rw_d = shift_q[0];
              if (!shift_q[0] && bus.rx_full_i) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                hold_d = 1'b1;
                scl_d  = 1'b1;
`else
                sda_d   = 1'b0;
                state_d = IGNORE;
`endif
              end else begin
                sda_d   = 1'b1;
                state_d = ADDR_ACK;
              end
            end else begin
              sda_d   = 1'b0;
              state_d = IGNORE;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            sda_d  = 1'b0;
            cnt_d  = 3'd7;
            last_d = 1'b0;
            if (!rw_q) begin
              state_d = RX_DATA;
            end else begin
              state_d = TX_DATA;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
              if (bus.tx_empty_i) begin
                hold_d = 1'b1;
                scl_d  = 1'b1;
              end else
`endif
              begin
                shift_d = load_byte;
                tx_rd_d = ~bus.tx_empty_i;
                sda_d   = ~load_byte[7];
              end
            end
          end
        end

        RX_DATA: begin
          if (hold_q) begin
            // stretched byte boundary: push and ACK once the RX FIFO has room;
            // SCL stays low for this cycle so SDA settles before release
            scl_d = 1'b1;
            if (!bus.rx_full_i) begin
              hold_d    = 1'b0;
              rx_data_d = shift_q;
              rx_wr_d   = 1'b1;
              sda_d     = 1'b1;
              state_d   = RX_ACK;
            end
          end else if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (cnt_q == 3'd0) last_d = 1'b1;
            else               cnt_d  = cnt_q - 3'd1;
          end else if (scl_fall && last_q) begin
            last_d = 1'b0;
            if (!bus.rx_full_i) begin
              rx_data_d = shift_q;
              rx_wr_d   = 1'b1;
              sda_d     = 1'b1;
              state_d   = RX_ACK;
            end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
              hold_d = 1'b1;
              scl_d  = 1'b1;
`else
              sda_d   = 1'b0;
              nack_d  = 1'b1;
              state_d = RX_ACK;
`endif
            end
          end
        end

        RX_ACK: begin
          if (scl_fall) begin
            sda_d   = 1'b0;
            cnt_d   = 3'd7;
            last_d  = 1'b0;
            nack_d  = 1'b0;
            state_d = nack_q ? IGNORE : RX_DATA;
          end
        end

        TX_DATA: begin
          if (hold_q) begin
            // stretched until the TX FIFO has a byte, then load and pop
            scl_d = 1'b1;
            if (!bus.tx_empty_i) begin
              hold_d  = 1'b0;
              shift_d = bus.tx_data_i;
              tx_rd_d = 1'b1;
              sda_d   = ~bus.tx_data_i[7];
            end
          end else if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_d   = 1'b0;
              state_d = TX_ACK;
            end else begin
              cnt_d   = cnt_q - 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
              sda_d   = ~shift_q[6];
            end
          end
        end

        TX_ACK: begin
          if (scl_rise) begin
            ack_d = sda_s;
          end else if (scl_fall) begin
            if (!ack_q) begin
              state_d = TX_DATA;
              cnt_d   = 3'd7;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
              if (bus.tx_empty_i) begin
                hold_d = 1'b1;
                scl_d  = 1'b1;
                sda_d  = 1'b0;
              end else
`endif
              begin
                shift_d = load_byte;
                tx_rd_d = ~bus.tx_empty_i;
                sda_d   = ~load_byte[7];
              end
            end else begin
              sda_d   = 1'b0;
              state_d = IGNORE;
            end
          end
        end

        IGNORE: sda_d = 1'b0;

        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sda_low_en_o = sda_q;
  assign bus.scl_low_en_o = scl_q;
  assign bus.tx_rd_en_o   = tx_rd_q;
  assign bus.rx_wr_en_o   = rx_wr_q;
  assign bus.rx_data_o    = rx_data_q;
  assign rw_o             = rw_q;
  assign busy_o           = busy_q;

endmodule
